alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Next-generation MIPS execute-stage ALU with a registered result and a valid/ready handshake. Single-cycle logic, shift and compare ops complete in one clock. An iterative multiply/divide unit writes architectural HI/LO registers. The unit sits between the decode/ID-EX pipeline register and EX-MEM, and stalls the pipe through o_ready while a multiply or divide is in flight.

Parameters:
NB_DATA, 32, datapath width; must be an even power of two, at least 8.
NB_OPERATION, 5, opcode width.
NB_SHAMT, $clog2(NB_DATA), shift-amount bits taken from i_data_b.

Ports:
i_clock  in  1  clock; all state changes on the rising edge.
i_reset  in  1  synchronous, active-low reset.
i_valid  in  1  operation request.
o_ready  out  1  unit can accept a request this cycle.
i_op  in  NB_OPERATION  operation code.
i_data_a  in  NB_DATA  operand A (rs).
i_data_b  in  NB_DATA  operand B (rt/imm/shamt).
i_flush  in  1  abort any in-flight mul/div; HI/LO untouched.
o_valid  out  1  o_result valid, one-cycle pulse per accepted op.
o_result  out  NB_DATA  registered result.
o_hi  out  NB_DATA  current HI register.
o_lo  out  NB_DATA  current LO register.

Behaviour:
- Reset (i_reset=0 at an edge): state IDLE, counter 0, o_valid=0, o_result=0, HI=LO=0. Applies mid-operation and aborts any mul/div. Reset has priority over i_flush and over accept.
- A request is accepted at an edge when i_valid=1, o_ready=1 and i_flush=0. o_ready = (state==IDLE).
- Opcodes (op: result):
  - 0 ADD: a+b. 1 SUB: a-b. 2 AND. 3 OR. 4 XOR. 5 NOR: ~(a|b).
  - 6 SRL, 7 SLL, 8 SRA (sign fill), 9 SLA (same as SLL). Shift amount is b[NB_SHAMT-1:0]; upper bits of b are ignored.
  - 10 SLT: signed compare, result 1 or 0. 11 LUI: b << NB_DATA/2. 12 SLTU: unsigned compare.
  - 13 MULT, 14 MULTU, 15 DIV, 16 DIVU.
  - 17 MFHI: HI. 18 MFLO: LO.
  - 19 MTHI: HI<=a, result=a. 20 MTLO: LO<=a, result=a.
  - Any other code: result all-ones.
- Wrap-around: ADD and SUB wrap modulo 2^NB_DATA; no overflow flag.
- Single-cycle ops: accept at edge e0 -> o_result and o_valid=1 after e0. o_valid returns to 0 after the next edge unless another op is accepted there. Back-to-back accepts every cycle are allowed.
- Mul/div FSM: IDLE -> MUL|DIV -> FIX -> IDLE.
  - Accept at e0 latches operand magnitudes (absolute value for signed ops) and the result signs, and sets counter=0.
  - Edges e1..eNB_DATA perform one iteration each: shift-add for MUL, restoring subtract for DIV. The counter increments each iteration. At counter=NB_DATA-1 the state moves to FIX.
  - At e(NB_DATA+1) FIX applies sign correction, writes HI/LO, sets o_result=new LO and o_valid=1, and returns to IDLE.
  - Total: o_valid after edge e0+NB_DATA+1; o_ready is low for NB_DATA+1 cycles.
- MULT/MULTU: {HI,LO} = full 2*NB_DATA-bit product, signed or unsigned.
- DIV/DIVU: LO=quotient, HI=remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: HI=a, LO=all-ones for both DIV and DIVU. The op still takes the full latency. No exception.
- Signed corner: DIV of most-negative by -1 gives LO=most-negative, HI=0.
- i_flush=1 at an edge:
  - In MUL/DIV/FIX: state goes to IDLE, no o_valid, HI/LO unchanged.
  - In IDLE: no accept and o_valid=0.
- While busy, i_valid is ignored and the requester must hold the request. MFHI/MFLO therefore never observe a partial HI/LO.
- o_hi and o_lo are updated only by FIX, MTHI, MTLO or reset.

Test Plan:
1. ADD 0xFFFFFFFF+1, then SRA 0x80000000 with b=36 on back-to-back cycles -> o_valid high 2 consecutive cycles; results 0x00000000, then 0xF8000000 (shift by 4).
2. MULT a=-3 (0xFFFFFFFD), b=5 -> o_ready low 33 cycles; o_valid after edge e0+33; HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU of the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
3. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU a=0x1234, b=0 -> HI=0x00001234, LO=0xFFFFFFFF after full latency; following MFHI -> o_result=0x00001234.
5. Start MULT with HI/LO=0xAAAA/0x5555, pulse i_flush at e0+10 -> no o_valid, o_ready high next cycle, HI/LO still 0xAAAA/0x5555; repeat with i_reset=0 at e0+10 -> all outputs and HI/LO 0.
6. SLT vs SLTU with a=0xFFFFFFFF, b=1 -> 1 and 0; NOR 0xF0F0F0F0,0x0F0F0F00 -> 0x0000000F; LUI b=0x1234 -> 0x12340000; op=31 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: one-cycle logic/shift/compare ops plus an iterative
// multiply/divide unit that owns the architectural HI/LO registers.
module alu_muldiv #(
   parameter int NB_DATA      = 32,
   parameter int NB_OPERATION = 5,
   parameter int NB_SHAMT     = $clog2(NB_DATA)
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [NB_OPERATION-1:0] i_op,
   input  logic [NB_DATA-1:0]      i_data_a,
   input  logic [NB_DATA-1:0]      i_data_b,
   input  logic                    i_flush,
   output logic                    o_valid,
   output logic [NB_DATA-1:0]      o_result,
   output logic [NB_DATA-1:0]      o_hi,
   output logic [NB_DATA-1:0]      o_lo
);

   localparam int NB_CNT = $clog2(NB_DATA);

   localparam logic [NB_OPERATION-1:0] OP_ADD   = NB_OPERATION'(0);
   localparam logic [NB_OPERATION-1:0] OP_SUB   = NB_OPERATION'(1);
   localparam logic [NB_OPERATION-1:0] OP_AND   = NB_OPERATION'(2);
   localparam logic [NB_OPERATION-1:0] OP_OR    = NB_OPERATION'(3);
   localparam logic [NB_OPERATION-1:0] OP_XOR   = NB_OPERATION'(4);
   localparam logic [NB_OPERATION-1:0] OP_NOR   = NB_OPERATION'(5);
   localparam logic [NB_OPERATION-1:0] OP_SRL   = NB_OPERATION'(6);
   localparam logic [NB_OPERATION-1:0] OP_SLL   = NB_OPERATION'(7);
   localparam logic [NB_OPERATION-1:0] OP_SRA   = NB_OPERATION'(8);
   localparam logic [NB_OPERATION-1:0] OP_SLA   = NB_OPERATION'(9);
   localparam logic [NB_OPERATION-1:0] OP_SLT   = NB_OPERATION'(10);
   localparam logic [NB_OPERATION-1:0] OP_LUI   = NB_OPERATION'(11);
   localparam logic [NB_OPERATION-1:0] OP_SLTU  = NB_OPERATION'(12);
   localparam logic [NB_OPERATION-1:0] OP_MULT  = NB_OPERATION'(13);
   localparam logic [NB_OPERATION-1:0] OP_MULTU = NB_OPERATION'(14);
   localparam logic [NB_OPERATION-1:0] OP_DIV   = NB_OPERATION'(15);
   localparam logic [NB_OPERATION-1:0] OP_DIVU  = NB_OPERATION'(16);
   localparam logic [NB_OPERATION-1:0] OP_MFHI  = NB_OPERATION'(17);
   localparam logic [NB_OPERATION-1:0] OP_MFLO  = NB_OPERATION'(18);
   localparam logic [NB_OPERATION-1:0] OP_MTHI  = NB_OPERATION'(19);
   localparam logic [NB_OPERATION-1:0] OP_MTLO  = NB_OPERATION'(20);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   function automatic logic [NB_DATA-1:0] negate_if(input logic [NB_DATA-1:0] v, input logic neg);
      return neg ? ({NB_DATA{1'b0}} - v) : v;
   endfunction

   state_t                 state_r, state_s;
   logic [NB_CNT-1:0]      cnt_r, cnt_s;
   logic [2*NB_DATA-1:0]   acc_r, acc_s;
   logic [NB_DATA-1:0]     opnd_r, opnd_s;
   logic [NB_DATA-1:0]     a_r, a_s;
   logic                   neg_lo_r, neg_lo_s;
   logic                   neg_hi_r, neg_hi_s;
   logic                   div0_r, div0_s;
   logic                   is_div_r, is_div_s;
   logic [NB_DATA-1:0]     result_r, result_s;
   logic                   valid_r, valid_s;
   logic [NB_DATA-1:0]     hi_r, hi_s;
   logic [NB_DATA-1:0]     lo_r, lo_s;

   logic [NB_DATA-1:0]     alu_s;
   logic [NB_SHAMT-1:0]    shamt_s;
   logic                   accept_s;
   logic                   signed_op_s;
   logic                   sign_a_s;
   logic                   sign_b_s;
   logic [NB_DATA:0]       mul_sum_s;
   logic [NB_DATA:0]       div_trial_s;
   logic [2*NB_DATA-1:0]   mul_step_s;
   logic [2*NB_DATA-1:0]   div_step_s;
   logic [2*NB_DATA-1:0]   prod_fix_s;

   assign shamt_s     = i_data_b[NB_SHAMT-1:0];
   assign accept_s    = i_valid & (state_r == ST_IDLE) & ~i_flush;
   assign signed_op_s = (i_op == OP_MULT) | (i_op == OP_DIV);
   assign sign_a_s    = signed_op_s & i_data_a[NB_DATA-1];
   assign sign_b_s    = signed_op_s & i_data_b[NB_DATA-1];

   // Shift-add keeps the multiplier in the low half and the running sum in the high half.
   assign mul_sum_s   = {1'b0, acc_r[2*NB_DATA-1:NB_DATA]}
                      + (acc_r[0] ? {1'b0, opnd_r} : {(NB_DATA+1){1'b0}});
   assign mul_step_s  = {mul_sum_s, acc_r[NB_DATA-1:1]};
   // Restoring divide: remainder in the high half, quotient bits shift in at the bottom.
   assign div_trial_s = acc_r[2*NB_DATA-1:NB_DATA-1] - {1'b0, opnd_r};
   assign div_step_s  = div_trial_s[NB_DATA] ? {acc_r[2*NB_DATA-2:0], 1'b0}
                                             : {div_trial_s[NB_DATA-1:0], acc_r[NB_DATA-2:0], 1'b1};
   assign prod_fix_s  = neg_lo_r ? ({(2*NB_DATA){1'b0}} - acc_r) : acc_r;

   // Single-cycle result selection.
   always_comb begin
      alu_s = {NB_DATA{1'b1}};
      case (i_op)
         OP_ADD:           alu_s = i_data_a + i_data_b;
         OP_SUB:           alu_s = i_data_a - i_data_b;
         OP_AND:           alu_s = i_data_a & i_data_b;
         OP_OR:            alu_s = i_data_a | i_data_b;
         OP_XOR:           alu_s = i_data_a ^ i_data_b;
         OP_NOR:           alu_s = ~(i_data_a | i_data_b);
         OP_SRL:           alu_s = i_data_a >> shamt_s;
         OP_SLL, OP_SLA:   alu_s = i_data_a << shamt_s;
         OP_SRA:           alu_s = NB_DATA'($signed(i_data_a) >>> shamt_s);
         OP_SLT:           alu_s = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
         OP_SLTU:          alu_s = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
         OP_LUI:           alu_s = i_data_b << (NB_DATA/2);
         OP_MFHI:          alu_s = hi_r;
         OP_MFLO:          alu_s = lo_r;
         OP_MTHI, OP_MTLO: alu_s = i_data_a;
         default:          alu_s = {NB_DATA{1'b1}};
      endcase
   end

   // Next-state and datapath update for the handshake and mul/div sequencer.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      acc_s    = acc_r;
      opnd_s   = opnd_r;
      a_s      = a_r;
      neg_lo_s = neg_lo_r;
      neg_hi_s = neg_hi_r;
      div0_s   = div0_r;
      is_div_s = is_div_r;
      result_s = result_r;
      valid_s  = 1'b0;
      hi_s     = hi_r;
      lo_s     = lo_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (i_op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_s = (i_op == OP_DIV) | (i_op == OP_DIVU);
                     state_s  = is_div_s ? ST_DIV : ST_MUL;
                     cnt_s    = {NB_CNT{1'b0}};
                     acc_s    = {{NB_DATA{1'b0}}, negate_if(i_data_a, sign_a_s)};
                     opnd_s   = negate_if(i_data_b, sign_b_s);
                     a_s      = i_data_a;
                     neg_lo_s = sign_a_s ^ sign_b_s;
                     neg_hi_s = sign_a_s;
                     div0_s   = (i_data_b == {NB_DATA{1'b0}});
                  end
                  OP_MTHI: begin
                     hi_s     = i_data_a;
                     result_s = alu_s;
                     valid_s  = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_s     = i_data_a;
                     result_s = alu_s;
                     valid_s  = 1'b1;
                  end
                  default: begin
                     result_s = alu_s;
                     valid_s  = 1'b1;
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (i_flush) begin
               state_s = ST_IDLE;
            end else begin
               acc_s   = (state_r == ST_DIV) ? div_step_s : mul_step_s;
               cnt_s   = cnt_r + NB_CNT'(1);
               state_s = (cnt_r == NB_CNT'(NB_DATA-1)) ? ST_FIX : state_r;
            end
         end
         ST_FIX: begin
            state_s = ST_IDLE;
            if (i_flush) begin
               valid_s = 1'b0;
            end else begin
               if (!is_div_r) begin
                  {hi_s, lo_s} = prod_fix_s;
               end else if (div0_r) begin
                  hi_s = a_r;
                  lo_s = {NB_DATA{1'b1}};
               end else begin
                  lo_s = negate_if(acc_r[NB_DATA-1:0], neg_lo_r);
                  hi_s = negate_if(acc_r[2*NB_DATA-1:NB_DATA], neg_hi_r);
               end
               result_s = lo_s;
               valid_s  = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over flush and accept.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {NB_CNT{1'b0}};
         acc_r    <= {(2*NB_DATA){1'b0}};
         opnd_r   <= {NB_DATA{1'b0}};
         a_r      <= {NB_DATA{1'b0}};
         neg_lo_r <= 1'b0;
         neg_hi_r <= 1'b0;
         div0_r   <= 1'b0;
         is_div_r <= 1'b0;
         result_r <= {NB_DATA{1'b0}};
         valid_r  <= 1'b0;
         hi_r     <= {NB_DATA{1'b0}};
         lo_r     <= {NB_DATA{1'b0}};
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         acc_r    <= acc_s;
         opnd_r   <= opnd_s;
         a_r      <= a_s;
         neg_lo_r <= neg_lo_s;
         neg_hi_r <= neg_hi_s;
         div0_r   <= div0_s;
         is_div_r <= is_div_s;
         result_r <= result_s;
         valid_r  <= valid_s;
         hi_r     <= hi_s;
         lo_r     <= lo_s;
      end
   end

   assign o_ready  = (state_r == ST_IDLE);
   assign o_valid  = valid_r;
   assign o_result = result_r;
   assign o_hi     = hi_r;
   assign o_lo     = lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: expectations are queued at issue time and
// checked against o_result/o_hi/o_lo whenever o_valid pulses.
module tb_alu_muldiv;

   localparam int LAT = 33;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [4:0]  i_op;
   logic [31:0] i_data_a;
   logic [31:0] i_data_b;
   logic        i_flush;
   logic        o_valid;
   logic [31:0] o_result;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;

   alu_muldiv dut (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_data_a (i_data_a),
      .i_data_b (i_data_b),
      .i_flush  (i_flush),
      .o_valid  (o_valid),
      .o_result (o_result),
      .o_hi     (o_hi),
      .o_lo     (o_lo)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every o_valid pulse must match the oldest queued expectation.
   always @(negedge i_clock) begin
      if (o_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_result"}, o_result, e.res);
            check({e.tag, "_hi"}, o_hi, e.hi);
            check({e.tag, "_lo"}, o_lo, e.lo);
         end
      end
   end

   task automatic single(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] res);
      exp_t e;
      @(negedge i_clock);
      i_valid  = 1'b1;
      i_op     = op;
      i_data_a = a;
      i_data_b = b;
      if (op == 5'd19) m_hi = a;
      if (op == 5'd20) m_lo = a;
      e.tag = tag; e.res = res; e.hi = m_hi; e.lo = m_lo;
      sb.push_back(e);
   endtask

   task automatic release_req();
      @(negedge i_clock);
      i_valid = 1'b0;
   endtask

   task automatic muldiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      int   n;
      @(negedge i_clock);
      i_valid  = 1'b1;
      i_op     = op;
      i_data_a = a;
      i_data_b = b;
      m_hi = ehi;
      m_lo = elo;
      e.tag = tag; e.res = elo; e.hi = ehi; e.lo = elo;
      sb.push_back(e);
      @(negedge i_clock);
      i_valid = 1'b0;
      n = 0;
      while (o_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge i_clock);
      end
      check({tag, "_busy_cycles"}, n, LAT);
      check({tag, "_valid_at_done"}, {31'd0, o_valid}, 32'd1);
   endtask

   initial begin
      i_reset  = 1'b0;
      i_valid  = 1'b0;
      i_op     = 5'd0;
      i_data_a = 32'h0;
      i_data_b = 32'h0;
      i_flush  = 1'b0;
      repeat (2) @(posedge i_clock);
      @(negedge i_clock);
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_result", o_result, 32'h0);
      check("rst_hi", o_hi, 32'h0);
      check("rst_lo", o_lo, 32'h0);
      i_reset = 1'b1;

      // Back-to-back single-cycle ops
      single(5'd0, 32'hFFFF_FFFF, 32'h1, "add_wrap", 32'h0);
      single(5'd8, 32'h8000_0000, 32'd36, "sra_amt", 32'hF800_0000);
      single(5'd1, 32'h0, 32'h1, "sub_wrap", 32'hFFFF_FFFF);
      single(5'd7, 32'h1, 32'd33, "sll", 32'h2);
      single(5'd9, 32'h3, 32'd4, "sla", 32'h30);
      single(5'd6, 32'h8000_0000, 32'd31, "srl", 32'h1);
      single(5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, "and", 32'h00F0_1200);
      single(5'd3, 32'hF000_0001, 32'h0000_0F00, "or", 32'hF000_0F01);
      single(5'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, "xor", 32'hF0F0_0F0F);
      release_req();

      // Multiply, signed and unsigned
      muldiv(5'd13, 32'hFFFF_FFFD, 32'd5, "mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      muldiv(5'd14, 32'hFFFF_FFFD, 32'd5, "multu", 32'h0000_0004, 32'hFFFF_FFF1);

      // Divide corners
      muldiv(5'd15, 32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      muldiv(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg", 32'h0, 32'h8000_0000);
      muldiv(5'd16, 32'd100, 32'd7, "divu", 32'd2, 32'd14);
      muldiv(5'd15, 32'hFFFF_FFFB, 32'h0, "div_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      muldiv(5'd16, 32'h1234, 32'h0, "divu_zero", 32'h0000_1234, 32'hFFFF_FFFF);
      single(5'd17, 32'h0, 32'h0, "mfhi", 32'h0000_1234);
      single(5'd18, 32'h0, 32'h0, "mflo", 32'hFFFF_FFFF);
      release_req();

      // Flush mid-multiply leaves HI/LO alone
      single(5'd19, 32'h0000_AAAA, 32'h0, "mthi", 32'h0000_AAAA);
      single(5'd20, 32'h0000_5555, 32'h0, "mtlo", 32'h0000_5555);
      @(negedge i_clock);
      i_valid = 1'b1; i_op = 5'd13; i_data_a = 32'd3; i_data_b = 32'd5;
      @(negedge i_clock);
      i_valid = 1'b0;
      repeat (9) @(negedge i_clock);
      i_flush = 1'b1;
      @(negedge i_clock);
      i_flush = 1'b0;
      check("flush_ready", {31'd0, o_ready}, 32'd1);
      check("flush_valid", {31'd0, o_valid}, 32'd0);
      check("flush_hi", o_hi, 32'h0000_AAAA);
      check("flush_lo", o_lo, 32'h0000_5555);
      repeat (40) @(negedge i_clock);
      check("flush_hi_later", o_hi, 32'h0000_AAAA);

      // Reset mid-multiply clears everything
      @(negedge i_clock);
      i_valid = 1'b1; i_op = 5'd13; i_data_a = 32'd3; i_data_b = 32'd5;
      @(negedge i_clock);
      i_valid = 1'b0;
      repeat (9) @(negedge i_clock);
      i_reset = 1'b0;
      @(negedge i_clock);
      i_reset = 1'b1;
      m_hi = 32'h0;
      m_lo = 32'h0;
      check("mrst_ready", {31'd0, o_ready}, 32'd1);
      check("mrst_valid", {31'd0, o_valid}, 32'd0);
      check("mrst_result", o_result, 32'h0);
      check("mrst_hi", o_hi, 32'h0);
      check("mrst_lo", o_lo, 32'h0);
      repeat (40) @(negedge i_clock);

      // Compares, NOR, LUI, illegal opcode
      single(5'd10, 32'hFFFF_FFFF, 32'h1, "slt", 32'h1);
      single(5'd12, 32'hFFFF_FFFF, 32'h1, "sltu", 32'h0);
      single(5'd5, 32'hF0F0_F0F0, 32'h0F0F_0F00, "nor", 32'h0000_000F);
      single(5'd11, 32'h0, 32'h0000_1234, "lui", 32'h1234_0000);
      single(5'd31, 32'h1, 32'h2, "illegal", 32'hFFFF_FFFF);
      release_req();

      repeat (3) @(negedge i_clock);
      check("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
